// File: rtl/reg40_wb_pkg.sv
// Shared types for the 40-word register-file write-back arbiter.
// Entry data is stored at MAX_WIDTH; the top narrows it back to WIDTH.
package reg40_wb_pkg;

    localparam int NUM_REQ   = 3;
    localparam int NUM_WORDS = 40;
    localparam int ADDR_W    = 6;
    localparam int MAX_WIDTH = 64;

    typedef logic [1:0] rr_ptr_t;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [MAX_WIDTH-1:0] data;
    } wb_entry_t;

    function automatic rr_ptr_t rr_next(input rr_ptr_t p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

endpackage

// File: rtl/reg40_wb_fifo.sv
// Per-requester write FIFO: DEPTH entries (power of two), registered count.
// Caller never pushes when full nor pops when empty.
module reg40_wb_fifo
    import reg40_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  wb_entry_t                  push_entry,
    input  logic                       pop,
    output wb_entry_t                  head,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_entry_t        mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Storage needs no reset; count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/reg_40_wb_arbiter.sv
// Dual-port write-back arbiter for the 40-word register file.
// Define REG40_WB_OOB_CHECK_EN to drop addr >= 40 and raise sticky err_oob.
module reg_40_wb_arbiter
    import reg40_wb_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [WIDTH-1:0]  req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [WIDTH-1:0]  req1_data,
    output logic              req1_ready,
    input  logic              req2_valid,
    input  logic [ADDR_W-1:0] req2_addr,
    input  logic [WIDTH-1:0]  req2_data,
    output logic              req2_ready,
    output logic              wr0_en,
    output logic [ADDR_W-1:0] wr0_addr,
    output logic [WIDTH-1:0]  wr0_data,
    output logic              wr1_en,
    output logic [ADDR_W-1:0] wr1_addr,
    output logic [WIDTH-1:0]  wr1_data,
    output logic              idle,
    output logic              err_oob
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [NUM_REQ-1:0] valid;
    logic [NUM_REQ-1:0] ready;
    logic [NUM_REQ-1:0] push;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] empty;
    wb_entry_t          in_entry [NUM_REQ];
    wb_entry_t          head     [NUM_REQ];
    logic [CNT_W-1:0]   count    [NUM_REQ];

    rr_ptr_t rr_ptr;
    rr_ptr_t rr_nxt;
    rr_ptr_t sel0;
    rr_ptr_t sel1;
    rr_ptr_t idx;
    logic    grant0;
    logic    grant1;

    assign valid = {req2_valid, req1_valid, req0_valid};
    assign in_entry[0] = '{addr: req0_addr, data: MAX_WIDTH'(req0_data)};
    assign in_entry[1] = '{addr: req1_addr, data: MAX_WIDTH'(req1_data)};
    assign in_entry[2] = '{addr: req2_addr, data: MAX_WIDTH'(req2_data)};

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_req
        reg40_wb_fifo #(
            .DEPTH(DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .push      (push[i]),
            .push_entry(in_entry[i]),
            .pop       (pop[i]),
            .head      (head[i]),
            .count     (count[i])
        );
        assign ready[i] = count[i] < CNT_W'(DEPTH);
        assign empty[i] = count[i] == '0;
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign req2_ready = ready[2];

`ifdef REG40_WB_OOB_CHECK_EN
    logic [NUM_REQ-1:0] oob;

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            oob[i] = in_entry[i].addr >= ADDR_W'(NUM_WORDS);
        end
    end

    // Out-of-range writes are consumed but never reach a FIFO.
    assign push = valid & ready & ~oob;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_oob <= 1'b0;
        end else if (|(valid & ready & oob)) begin
            err_oob <= 1'b1;
        end
    end
`else
    assign push    = valid & ready;
    assign err_oob = 1'b0;
`endif

    // Walk heads from rr_ptr; port 1 never takes port 0's address.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        sel0   = '0;
        sel1   = '0;
        pop    = '0;
        idx    = rr_ptr;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!empty[idx]) begin
                if (!grant0) begin
                    grant0 = 1'b1;
                    sel0   = idx;
                end else if (!grant1 && head[idx].addr != head[sel0].addr) begin
                    grant1 = 1'b1;
                    sel1   = idx;
                end
            end
            idx = rr_next(idx);
        end
        if (grant0) begin
            pop[sel0] = 1'b1;
        end
        if (grant1) begin
            pop[sel1] = 1'b1;
        end
        if (grant1) begin
            rr_nxt = rr_next(sel1);
        end else if (grant0) begin
            rr_nxt = rr_next(sel0);
        end else begin
            rr_nxt = rr_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr   <= '0;
            wr0_en   <= 1'b0;
            wr0_addr <= '0;
            wr0_data <= '0;
            wr1_en   <= 1'b0;
            wr1_addr <= '0;
            wr1_data <= '0;
        end else begin
            rr_ptr <= rr_nxt;
            wr0_en <= grant0;
            wr1_en <= grant1;
            if (grant0) begin
                wr0_addr <= head[sel0].addr;
                wr0_data <= head[sel0].data[WIDTH-1:0];
            end
            if (grant1) begin
                wr1_addr <= head[sel1].addr;
                wr1_data <= head[sel1].data[WIDTH-1:0];
            end
        end
    end

    assign idle = (&empty) & ~wr0_en & ~wr1_en;

endmodule

// File: tb/tb_reg_40_wb_arbiter.sv
// Randomized bench for reg_40_wb_arbiter against a queue-based reference model.
// Build with REG40_WB_OOB_CHECK_EN to match an OOB-checking DUT.
module tb_reg_40_wb_arbiter;

    localparam int WIDTH = 64;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  v;
    logic [5:0]  a [3];
    logic [63:0] d [3];
    logic [2:0]  rdy;
    logic        wr0_en, wr1_en, idle, err_oob;
    logic [5:0]  wr0_addr, wr1_addr;
    logic [63:0] wr0_data, wr1_data;

    always #5 clk = ~clk;

    reg_40_wb_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req0_valid(v[0]),
        .req0_addr (a[0]),
        .req0_data (d[0]),
        .req0_ready(rdy[0]),
        .req1_valid(v[1]),
        .req1_addr (a[1]),
        .req1_data (d[1]),
        .req1_ready(rdy[1]),
        .req2_valid(v[2]),
        .req2_addr (a[2]),
        .req2_data (d[2]),
        .req2_ready(rdy[2]),
        .wr0_en    (wr0_en),
        .wr0_addr  (wr0_addr),
        .wr0_data  (wr0_data),
        .wr1_en    (wr1_en),
        .wr1_addr  (wr1_addr),
        .wr1_data  (wr1_data),
        .idle      (idle),
        .err_oob   (err_oob)
    );

    typedef struct {
        int          r;
        logic [5:0]  a;
        logic [63:0] d;
    } ent_t;

    // All pending writes in arrival order, tagged with their requester.
    ent_t        mq [$];
    int          mrr;
    logic        x_en0, x_en1, x_err;
    logic [5:0]  x_a0, x_a1;
    logic [63:0] x_d0, x_d1;
    logic [2:0]  acc;
    logic [63:0] rf [64];
    int          n_checks = 0;
    int          n_pass = 0;
    bit          fair_on = 0;
    int          fcnt [3];
    int          fgap [3];
    int          fmax;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int mhead(input int n);
        foreach (mq[i]) if (mq[i].r == n) return i;
        return -1;
    endfunction

    function automatic int msize(input int n);
        int c = 0;
        foreach (mq[i]) if (mq[i].r == n) c++;
        return c;
    endfunction

    function automatic bit is_oob(input logic [5:0] ad);
`ifdef REG40_WB_OOB_CHECK_EN
        return ad >= 6'd40;
`else
        return 1'b0;
`endif
    endfunction

    // One clock: entered and left just after a falling edge.
    task automatic step();
        int g0, g1, h0, h1, h, n;
        bit hit;
        for (int k = 0; k < 3; k++) begin
            acc[k] = v[k] && (msize(k) < DEPTH);
            check($sformatf("ready%0d", k), rdy[k], msize(k) < DEPTH);
        end
        g0 = -1; g1 = -1; h0 = -1; h1 = -1;
        for (int j = 0; j < 3; j++) begin
            n = (mrr + j) % 3;
            h = mhead(n);
            if (h >= 0) begin
                if (g0 < 0) begin
                    g0 = n; h0 = h;
                end else if (g1 < 0 && mq[h].a != mq[h0].a) begin
                    g1 = n; h1 = h;
                end
            end
        end
        @(posedge clk);
        x_en0 = g0 >= 0;
        x_en1 = g1 >= 0;
        if (x_en0) begin x_a0 = mq[h0].a; x_d0 = mq[h0].d; end
        if (x_en1) begin x_a1 = mq[h1].a; x_d1 = mq[h1].d; end
        if (x_en1) begin
            mq.delete(h0 > h1 ? h0 : h1);
            mq.delete(h0 > h1 ? h1 : h0);
        end else if (x_en0) begin
            mq.delete(h0);
        end
        for (int k = 0; k < 3; k++) begin
            if (acc[k]) begin
                if (is_oob(a[k])) x_err = 1'b1;
                else mq.push_back('{r: k, a: a[k], d: d[k]});
            end
        end
        if (x_en1) mrr = (g1 + 1) % 3;
        else if (x_en0) mrr = (g0 + 1) % 3;
        #1;
        check("wr0_en", wr0_en, x_en0);
        check("wr0_addr", wr0_addr, x_a0);
        check("wr0_data", wr0_data, x_d0);
        check("wr1_en", wr1_en, x_en1);
        check("wr1_addr", wr1_addr, x_a1);
        check("wr1_data", wr1_data, x_d1);
        check("idle", idle, mq.size() == 0 && !x_en0 && !x_en1);
        check("err_oob", err_oob, x_err);
        if (wr0_en) rf[wr0_addr] = wr0_data;
        if (wr1_en) rf[wr1_addr] = wr1_data;
        if (fair_on) begin
            for (int k = 0; k < 3; k++) begin
                hit = (wr0_en && wr0_data[63:60] == 4'(k)) ||
                      (wr1_en && wr1_data[63:60] == 4'(k));
                if (hit) begin
                    fcnt[k]++;
                    fgap[k] = 0;
                end else begin
                    fgap[k]++;
                    if (fgap[k] > fmax) fmax = fgap[k];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        v = '0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_wr0_en", wr0_en, 1'b0);
        check("rst_wr1_en", wr1_en, 1'b0);
        check("rst_idle", idle, 1'b1);
        check("rst_ready", rdy, 3'b111);
        check("rst_err", err_oob, 1'b0);
        check("rst_addr", {wr0_addr, wr1_addr}, 12'd0);
        mq.delete();
        mrr = 0;
        x_en0 = 0; x_en1 = 0; x_err = 0;
        x_a0 = '0; x_a1 = '0; x_d0 = '0; x_d1 = '0;
        acc = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Keep an unaccepted request stable; otherwise apply the new one.
    task automatic offer(input int k, input bit val, input logic [5:0] ad,
                         input logic [63:0] dat);
        if (!(v[k] && !acc[k])) begin
            v[k] = val;
            a[k] = ad;
            d[k] = dat;
        end
    endtask

    initial begin
        int sent2;
        bit saw_low;
        v = '0;
        acc = '0;
        foreach (a[k]) begin a[k] = '0; d[k] = '0; end
        foreach (rf[k]) rf[k] = '0;
        do_reset();

        // Same-address collision with rr at 0.
        v = 3'b111;
        a[0] = 6'd7; d[0] = 64'hA;
        a[1] = 6'd7; d[1] = 64'hB;
        a[2] = 6'd3; d[2] = 64'hC;
        step();
        v = '0;
        step();
        check("coll_c1_wr0", {wr0_en, wr0_addr, wr0_data}, {1'b1, 6'd7, 64'hA});
        check("coll_c1_wr1", {wr1_en, wr1_addr, wr1_data}, {1'b1, 6'd3, 64'hC});
        step();
        check("coll_c2_wr0", {wr0_en, wr0_addr, wr0_data}, {1'b1, 6'd7, 64'hB});
        check("coll_c2_wr1_en", wr1_en, 1'b0);
        check("coll_reg7", rf[7], 64'hB);

        // Dual issue.
        do_reset();
        v = 3'b011;
        a[0] = 6'd5; d[0] = 64'hA;
        a[1] = 6'd9; d[1] = 64'hB;
        step();
        v = '0;
        step();
        check("dual_wr0", {wr0_en, wr0_addr, wr0_data}, {1'b1, 6'd5, 64'hA});
        check("dual_wr1", {wr1_en, wr1_addr, wr1_data}, {1'b1, 6'd9, 64'hB});

        // Out-of-range address.
        do_reset();
        v = 3'b010;
        a[1] = 6'd45; d[1] = 64'h5A;
        step();
        v = '0;
`ifdef REG40_WB_OOB_CHECK_EN
        check("oob_err_next", err_oob, 1'b1);
        step();
        check("oob_no_write", wr0_en, 1'b0);
        check("oob_err_sticky", err_oob, 1'b1);
`else
        check("oob_err_tied", err_oob, 1'b0);
        step();
        check("oob_issued", {wr0_en, wr0_addr}, {1'b1, 6'd45});
`endif
        step();

        // Fairness: all requesters always valid, distinct addresses.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            fcnt[k] = 0;
            fgap[k] = 0;
        end
        fmax = 0;
        for (int c = 0; c < 32; c++) begin
            if (c == 2) fair_on = 1;
            for (int k = 0; k < 3; k++)
                offer(k, 1'b1, 6'(10 + k), {4'(k), 60'(c)});
            step();
        end
        fair_on = 0;
        for (int k = 0; k < 3; k++)
            check($sformatf("fair_cnt%0d", k), fcnt[k] >= 19 && fcnt[k] <= 21, 1'b1);
        check("fair_maxwait", fmax <= 2, 1'b1);

        // Backpressure on requester 2 behind a same-address chain.
        do_reset();
        sent2 = 0;
        saw_low = 0;
        for (int c = 0; c < 60 && sent2 < 6; c++) begin
            offer(0, c < 12, 6'd7, 64'(100 + c));
            offer(1, c < 12, 6'd7, 64'(200 + c));
            offer(2, 1'b1, 6'd7, 64'(300 + sent2));
            if (!rdy[2]) saw_low = 1;
            step();
            if (acc[2]) sent2++;
        end
        check("bp_all_sent", sent2, 6);
        check("bp_ready_low", saw_low, 1'b1);
        v = '0;
        for (int c = 0; c < 20; c++) step();
        check("bp_drained", idle, 1'b1);

        // Random traffic with small address space to force collisions.
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 3; k++)
                offer(k, ($urandom % 3) != 0,
                      ($urandom % 16 == 0) ? 6'(40 + $urandom % 24) : 6'($urandom % 6),
                      {$urandom, $urandom});
            step();
        end
        v = '0;
        for (int c = 0; c < 20; c++) step();
        check("rand_drained", idle, 1'b1);

        // Reset in the middle of a backlog.
        do_reset();
        for (int c = 0; c < 5; c++) begin
            for (int k = 0; k < 3; k++) offer(k, 1'b1, 6'd7, 64'(c * 3 + k));
            step();
        end
        check("mid_backlog", rdy[0] && rdy[1] && rdy[2], 1'b0);
        do_reset();
        for (int c = 0; c < 10; c++) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
